// File: rtl/alu_seq64_if.sv
// alu_seq64_if: bundles the request channel, response channel and ALU pins
// of the 64-bit sequencer. The slave modport is the sequencer's view; the
// master modport is the view of whatever surrounds it (decode/ALU/consumer).
interface alu_seq64_if #(
   parameter int WORD_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_op;
   logic [2*WORD_W-1:0]   req_a;
   logic [2*WORD_W-1:0]   req_b;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [2*WORD_W-1:0]   rsp_data;
   logic                  rsp_cout;

   logic [WORD_W-1:0]     alu_a;
   logic [WORD_W-1:0]     alu_b;
   logic [2:0]            alu_control;
   logic [WORD_W-1:0]     alu_dout;
   logic                  alu_cout;

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready, alu_dout, alu_cout,
      output req_ready, rsp_valid, rsp_data, rsp_cout, alu_a, alu_b, alu_control
   );

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready, alu_dout, alu_cout,
      input  req_ready, rsp_valid, rsp_data, rsp_cout, alu_a, alu_b, alu_control
   );
endinterface

// File: rtl/alu_seq64.sv
// alu_seq64: drives an external 32-bit combinational ALU over several
// cycles to execute one 64-bit operation. The low half runs first, then the
// high half; for ADD a low-half carry is folded in with an extra increment
// pass on the high result. At most one operation is in flight.
//
// Optional feature macro: ALU_SEQ_STATS_EN
//   When defined, adds op_count (completed response handshakes, 32 bits)
//   and inc_count (entries into the increment pass, 16 bits), both wrapping.
//
// Every output is a flop; the next-value logic looks ahead at the next
// state, so the ALU pins never see a combinational path from req_*.
module alu_seq64 #(
   parameter int         WORD_W = 32,
   parameter logic [2:0] ADD_OP = 3'b000
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_seq64_if.slave  bus
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [31:0] op_count,
   output logic [15:0] inc_count
`endif
);

   localparam int DW = 2 * WORD_W;
   localparam logic [WORD_W-1:0] W_ZERO = {WORD_W{1'b0}};
   localparam logic [WORD_W-1:0] W_ONE  = {{(WORD_W-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0]     D_ZERO = {DW{1'b0}};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      INC  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nx;

   // captured request and intermediate results
   logic [2:0]          op_q;
   logic [2:0]          op_nx;
   logic [DW-1:0]       a_q;
   logic [DW-1:0]       a_nx;
   logic [DW-1:0]       b_q;
   logic [DW-1:0]       b_nx;
   logic [WORD_W-1:0]   res_lo_q;
   logic [WORD_W-1:0]   res_lo_nx;
   logic [WORD_W-1:0]   res_hi_q;
   logic [WORD_W-1:0]   res_hi_nx;
   logic                carry_q;
   logic                carry_nx;
   logic                hcout_q;
   logic                hcout_nx;
   logic                fcout_q;
   logic                fcout_nx;

   // registered outputs
   logic                req_ready_q;
   logic                req_ready_nx;
   logic                rsp_valid_q;
   logic                rsp_valid_nx;
   logic [DW-1:0]       rsp_data_q;
   logic [DW-1:0]       rsp_data_nx;
   logic                rsp_cout_q;
   logic                rsp_cout_nx;
   logic [WORD_W-1:0]   alu_a_q;
   logic [WORD_W-1:0]   alu_a_nx;
   logic [WORD_W-1:0]   alu_b_q;
   logic [WORD_W-1:0]   alu_b_nx;
   logic [2:0]          alu_ctl_q;
   logic [2:0]          alu_ctl_nx;

   // Next state and the datapath registers written in each state.
   always_comb begin
      state_nx  = state;
      op_nx     = op_q;
      a_nx      = a_q;
      b_nx      = b_q;
      res_lo_nx = res_lo_q;
      res_hi_nx = res_hi_q;
      carry_nx  = carry_q;
      hcout_nx  = hcout_q;
      fcout_nx  = fcout_q;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               op_nx    = bus.req_op;
               a_nx     = bus.req_a;
               b_nx     = bus.req_b;
               state_nx = LO;
            end else begin
               state_nx = IDLE;
            end
         end
         LO: begin
            res_lo_nx = bus.alu_dout;
            carry_nx  = bus.alu_cout;
            state_nx  = HI;
         end
         HI: begin
            res_hi_nx = bus.alu_dout;
            hcout_nx  = bus.alu_cout;
            // Only ADD chains the low carry; other ops keep halves independent.
            if ((op_q == ADD_OP) && carry_q) begin
               state_nx = INC;
            end else begin
               fcout_nx = bus.alu_cout;
               state_nx = DONE;
            end
         end
         INC: begin
            res_hi_nx = bus.alu_dout;
            // The high pass and the +1 pass cannot both carry, so OR is exact.
            fcout_nx  = hcout_q | bus.alu_cout;
            state_nx  = DONE;
         end
         DONE: begin
            if (bus.rsp_ready) begin
               state_nx = IDLE;
            end else begin
               state_nx = DONE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Output values for the state being entered, so the flops present them
   // for the whole of that state.
   always_comb begin
      req_ready_nx = 1'b0;
      rsp_valid_nx = 1'b0;
      rsp_data_nx  = D_ZERO;
      rsp_cout_nx  = 1'b0;
      alu_a_nx     = W_ZERO;
      alu_b_nx     = W_ZERO;
      alu_ctl_nx   = 3'b000;
      case (state_nx)
         IDLE: begin
            req_ready_nx = 1'b1;
         end
         LO: begin
            alu_a_nx   = a_nx[WORD_W-1:0];
            alu_b_nx   = b_nx[WORD_W-1:0];
            alu_ctl_nx = op_nx;
         end
         HI: begin
            alu_a_nx   = a_nx[DW-1:WORD_W];
            alu_b_nx   = b_nx[DW-1:WORD_W];
            alu_ctl_nx = op_nx;
         end
         INC: begin
            alu_a_nx   = res_hi_nx;
            alu_b_nx   = W_ONE;
            alu_ctl_nx = ADD_OP;
         end
         DONE: begin
            rsp_valid_nx = 1'b1;
            rsp_data_nx  = {res_hi_nx, res_lo_nx};
            rsp_cout_nx  = fcout_nx;
         end
         default: begin
            req_ready_nx = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset discards any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= 3'b000;
         a_q         <= D_ZERO;
         b_q         <= D_ZERO;
         res_lo_q    <= W_ZERO;
         res_hi_q    <= W_ZERO;
         carry_q     <= 1'b0;
         hcout_q     <= 1'b0;
         fcout_q     <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= D_ZERO;
         rsp_cout_q  <= 1'b0;
         alu_a_q     <= W_ZERO;
         alu_b_q     <= W_ZERO;
         alu_ctl_q   <= 3'b000;
      end else begin
         state       <= state_nx;
         op_q        <= op_nx;
         a_q         <= a_nx;
         b_q         <= b_nx;
         res_lo_q    <= res_lo_nx;
         res_hi_q    <= res_hi_nx;
         carry_q     <= carry_nx;
         hcout_q     <= hcout_nx;
         fcout_q     <= fcout_nx;
         req_ready_q <= req_ready_nx;
         rsp_valid_q <= rsp_valid_nx;
         rsp_data_q  <= rsp_data_nx;
         rsp_cout_q  <= rsp_cout_nx;
         alu_a_q     <= alu_a_nx;
         alu_b_q     <= alu_b_nx;
         alu_ctl_q   <= alu_ctl_nx;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_cout    = rsp_cout_q;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_control = alu_ctl_q;

`ifdef ALU_SEQ_STATS_EN
   logic rsp_fire;
   logic inc_entry;

   assign rsp_fire  = (state == DONE) && bus.rsp_ready;
   assign inc_entry = (state == HI) && (state_nx == INC);

   // Completed-handshake and increment-pass counters, both free-wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count  <= 32'd0;
         inc_count <= 16'd0;
      end else begin
         if (rsp_fire) begin
            op_count <= op_count + 32'd1;
         end else begin
            op_count <= op_count;
         end
         if (inc_entry) begin
            inc_count <= inc_count + 16'd1;
         end else begin
            inc_count <= inc_count;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq64.sv
// tb_alu_seq64: table-driven bench for alu_seq64 with a behavioural 32-bit
// ALU attached to the ALU pins (000 ADD, 001 AND, 010 OR, 011 XOR, 100 SUB
// with cout = borrow). Hand-written sequences cover reset, backpressure and
// reset in the middle of an operation.
module tb_alu_seq64;

   logic clk;
   logic rst_n;

   alu_seq64_if #(.WORD_W(32)) bus ();

`ifdef ALU_SEQ_STATS_EN
   logic [31:0] op_count;
   logic [15:0] inc_count;
`endif

   alu_seq64 #(.WORD_W(32), .ADD_OP(3'b000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus)
`ifdef ALU_SEQ_STATS_EN
      ,
      .op_count  (op_count),
      .inc_count (inc_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference 32-bit ALU.
   logic [32:0] alu_sum;
   logic [32:0] alu_diff;
   always_comb begin
      alu_sum      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      alu_diff     = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      bus.alu_dout = 32'd0;
      bus.alu_cout = 1'b0;
      case (bus.alu_control)
         3'b000: begin bus.alu_dout = alu_sum[31:0];  bus.alu_cout = alu_sum[32];  end
         3'b001: begin bus.alu_dout = bus.alu_a & bus.alu_b; end
         3'b010: begin bus.alu_dout = bus.alu_a | bus.alu_b; end
         3'b011: begin bus.alu_dout = bus.alu_a ^ bus.alu_b; end
         3'b100: begin bus.alu_dout = alu_diff[31:0]; bus.alu_cout = alu_diff[32]; end
         default: begin bus.alu_dout = 32'd0; end
      endcase
   end

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] data;
      logic        cout;
      int          lat;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   int checks;
   int errors;
   int exp_ops;
   int exp_incs;

   logic [2:0]  ctl_c1, ctl_c2;
   logic [31:0] alua_c1, alua_c2;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Issue one request from IDLE, wait (bounded) for the response, then
   // complete the handshake. lat counts cycles after the accept edge.
   task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] data, output logic cout, output int lat);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat     = 1;
      ctl_c1  = bus.alu_control;
      alua_c1 = bus.alu_a;
      ctl_c2  = 3'b111;
      alua_c2 = 32'd0;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 2) begin
            ctl_c2  = bus.alu_control;
            alua_c2 = bus.alu_a;
         end
      end
      data = bus.rsp_data;
      cout = bus.rsp_cout;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      if (lat < 20) begin
         exp_ops++;
         if (lat == 4) exp_incs++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
      check({tag, "_rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
      check({tag, "_rsp_data"},  bus.rsp_data, 64'd0);
      check({tag, "_rsp_cout"},  {63'd0, bus.rsp_cout}, 64'd0);
      check({tag, "_alu_a"},     {32'd0, bus.alu_a}, 64'd0);
      check({tag, "_alu_b"},     {32'd0, bus.alu_b}, 64'd0);
      check({tag, "_alu_ctl"},   {61'd0, bus.alu_control}, 64'd0);
   endtask

   initial begin
      logic [63:0] data;
      logic        cout;
      int          lat;
      int          guard;
      int          seen;

      checks   = 0;
      errors   = 0;
      exp_ops  = 0;
      exp_incs = 0;

      vecs[0]  = '{3'b000, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0, 4};
      vecs[1]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 4};
      vecs[2]  = '{3'b001, 64'hF0F0_0000_0000_FFFF, 64'hFFFF_FFFF_0000_00FF, 64'hF0F0_0000_0000_00FF, 1'b0, 3};
      vecs[3]  = '{3'b000, 64'd5, 64'd7, 64'd12, 1'b0, 3};
      vecs[4]  = '{3'b000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 3};
      vecs[5]  = '{3'b000, 64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 64'h0000_0004_0000_0000, 1'b0, 4};
      vecs[6]  = '{3'b010, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 64'h1F3F_5F7F_9FBF_DFFF, 1'b0, 3};
      vecs[7]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_FFFF_FFFF_0000, 64'hFFFF_0000_0000_FFFF, 1'b0, 3};
      vecs[8]  = '{3'b100, 64'h0000_0001_0000_0000, 64'h1, 64'h0000_0001_FFFF_FFFF, 1'b0, 3};
      vecs[9]  = '{3'b100, 64'h0, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b1, 3};
      vecs[10] = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4};

      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'b000;
      bus.req_a     = 64'd0;
      bus.req_b     = 64'd0;
      bus.rsp_ready = 1'b0;
      #12;
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors.
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, data, cout, lat);
         check($sformatf("v%0d_data", i), data, vecs[i].data);
         check($sformatf("v%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].cout});
         check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      end

      // Non-ADD op drives its own control code in both halves.
      run_op(3'b001, 64'hF0F0_0000_0000_FFFF, 64'hFFFF_FFFF_0000_00FF, data, cout, lat);
      check("and_ctl_lo", {61'd0, ctl_c1}, 64'd1);
      check("and_ctl_hi", {61'd0, ctl_c2}, 64'd1);
      check("and_alua_lo", {32'd0, alua_c1}, 64'h0000_FFFF);
      check("and_alua_hi", {32'd0, alua_c2}, 64'hF0F0_0000);
      check("and_lat", 64'(lat), 64'd3);

      // Backpressure: response held while a new request waits.
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b000;
      bus.req_a     = 64'h10;
      bus.req_b     = 64'h20;
      @(posedge clk); #1;
      bus.req_a     = 64'd100;
      bus.req_b     = 64'd1;
      guard = 0;
      while (!bus.rsp_valid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("bp_reach_done", {63'd0, bus.rsp_valid}, 64'd1);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp_req_ready_c%0d", c), {63'd0, bus.req_ready}, 64'd0);
         check($sformatf("bp_rsp_valid_c%0d", c), {63'd0, bus.rsp_valid}, 64'd1);
         check($sformatf("bp_rsp_data_c%0d", c), bus.rsp_data, 64'h30);
      end
      check("bp_alu_ctl_done", {61'd0, bus.alu_control}, 64'd0);
      check("bp_alu_a_done", {32'd0, bus.alu_a}, 64'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      exp_ops++;
      check("bp_idle_valid", {63'd0, bus.rsp_valid}, 64'd0);
      check("bp_idle_ready", {63'd0, bus.req_ready}, 64'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("bp_next_accept", {63'd0, bus.req_ready}, 64'd0);
      check("bp_next_lo_a", {32'd0, bus.alu_a}, 64'd100);
      guard = 0;
      while (!bus.rsp_valid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("bp_next_data", bus.rsp_data, 64'd101);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      exp_ops++;

      // Reset while in HI: op discarded, outputs drop asynchronously.
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b000;
      bus.req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.req_b     = 64'h1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_hi_alu_a", {32'd0, bus.alu_a}, 64'hFFFF_FFFF);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async");
      @(posedge clk); #2;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) seen++;
      end
      check("mid_rst_no_rsp", 64'(seen), 64'd0);
`ifdef ALU_SEQ_STATS_EN
      exp_ops  = 0;
      exp_incs = 0;
`endif
      run_op(3'b000, 64'd5, 64'd7, data, cout, lat);
      check("post_rst_data", data, 64'd12);
      check("post_rst_cout", {63'd0, cout}, 64'd0);
      check("post_rst_lat", 64'(lat), 64'd3);

`ifdef ALU_SEQ_STATS_EN
      check("stats_op_count", {32'd0, op_count}, 64'(exp_ops));
      check("stats_inc_count", {48'd0, inc_count}, 64'(exp_incs));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
